// File: rtl/vga_sync_if.sv
// Raster timing bundle between the sync generator (master) and its
// pixel/colour consumers (slave), which supply the pixel strobe.
interface vga_sync_if;
  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, video_on, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, video_on, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster counter and sync generator, advancing one pixel per pix_en
// strobe; controls are derived from the next coordinates so they never skew.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  vga_sync_if.master  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (vif.pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end

      // Decode from the coordinates being loaded this edge.
      hsync_d    = (hcount_d >= H_SYNC_BEG && hcount_d <= H_SYNC_END) ? HS_POL : ~HS_POL;
      vsync_d    = (vcount_d >= V_SYNC_BEG && vcount_d <= V_SYNC_END) ? VS_POL : ~VS_POL;
      video_on_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);

      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
      if (frame_start_d) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Reset parks the raster on the last pixel so the first strobe enters (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vif.hcount      = hcount_q;
  assign vif.vcount      = vcount_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing, a short-line
// variant for full vertical sweeps, and a tiny raster for frame_cnt wrap.
module tb_vga_sync_gen;

  logic clk;
  logic rst_d, rst_t, rst_s;

  int n_checks = 0;
  int n_pass   = 0;

  vga_sync_if if_d ();
  vga_sync_if if_t ();
  vga_sync_if if_s ();

  vga_sync_gen u_dut (
    .clk (clk),
    .rst (rst_d),
    .vif (if_d)
  );

  vga_sync_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1)
  ) u_tall (
    .clk (clk),
    .rst (rst_t),
    .vif (if_t)
  );

  vga_sync_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .vif (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference raster state for each instance.
  int   d_h, d_v, d_fc;
  logic d_fs;
  int   t_h, t_v, t_fc, t_frames;
  logic t_fs;
  int   s_h, s_v, s_fc, s_frames;
  logic s_fs;

  task automatic chk(input string tag, input int obs, input int exp_val);
    n_checks++;
    if (obs == exp_val) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int ht, input int vt, inout int h, inout int v,
                     inout logic fs, inout int fc);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    fs = (h == 0 && v == 0);
    if (fs) fc = (fc + 1) % 256;
  endtask

  // Active-low syncs: expected level is 0 inside the sync window.
  task automatic cmp(input string tag,
                     input int ha, input int hfp, input int hsw,
                     input int va, input int vfp, input int vsw,
                     input logic [9:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic vo,
                     input logic fs, input logic [7:0] fc,
                     input int eh, input int ev, input logic efs, input int efc);
    string p;
    p = $sformatf("%s(%0d,%0d)", tag, eh, ev);
    chk({p, ".hcount"},      int'(h),  eh);
    chk({p, ".vcount"},      int'(v),  ev);
    chk({p, ".hsync"},       int'(hs), (eh >= ha + hfp && eh <= ha + hfp + hsw - 1) ? 0 : 1);
    chk({p, ".vsync"},       int'(vs), (ev >= va + vfp && ev <= va + vfp + vsw - 1) ? 0 : 1);
    chk({p, ".video_on"},    int'(vo), (eh < ha && ev < va) ? 1 : 0);
    chk({p, ".frame_start"}, int'(fs), int'(efs));
    chk({p, ".frame_cnt"},   int'(fc), efc);
  endtask

  task automatic cmp_d(input string tag);
    cmp(tag, 640, 16, 96, 480, 10, 2,
        if_d.hcount, if_d.vcount, if_d.hsync, if_d.vsync, if_d.video_on,
        if_d.frame_start, if_d.frame_cnt, d_h, d_v, d_fs, d_fc);
  endtask

  task automatic cmp_t(input string tag);
    cmp(tag, 4, 1, 1, 480, 10, 2,
        if_t.hcount, if_t.vcount, if_t.hsync, if_t.vsync, if_t.video_on,
        if_t.frame_start, if_t.frame_cnt, t_h, t_v, t_fs, t_fc);
  endtask

  task automatic cmp_s(input string tag);
    cmp(tag, 4, 1, 1, 2, 1, 1,
        if_s.hcount, if_s.vcount, if_s.hsync, if_s.vsync, if_s.video_on,
        if_s.frame_start, if_s.frame_cnt, s_h, s_v, s_fs, s_fc);
  endtask

  // One clock on the default instance with the given strobe value.
  task automatic step_d(input logic pe, input string tag);
    if_d.pix_en = pe;
    tick();
    if_d.pix_en = 1'b0;
    if (pe) adv(800, 525, d_h, d_v, d_fs, d_fc);
    else    d_fs = 1'b0;
    cmp_d(tag);
  endtask

  // Nominal cadence: strobe then three idle clocks.
  task automatic pixel4_d(input string tag);
    step_d(1'b1, tag);
    for (int k = 0; k < 3; k++) step_d(1'b0, tag);
  endtask

  initial begin
    rst_d = 1'b1; rst_t = 1'b1; rst_s = 1'b1;
    if_d.pix_en = 1'b0; if_t.pix_en = 1'b0; if_s.pix_en = 1'b0;

    // ---------------- default 800x525 instance ----------------
    for (int i = 0; i < 3; i++) begin
      if_d.pix_en = ~if_d.pix_en;
      tick();
    end
    d_h = 799; d_v = 524; d_fs = 1'b0; d_fc = 0;
    cmp_d("rst");
    $display("default: reset held 3 clks with pix_en toggling");

    rst_d = 1'b0;
    step_d(1'b0, "idle");
    step_d(1'b1, "entry");
    chk("entry.frame_start_hi", int'(if_d.frame_start), 1);
    chk("entry.frame_cnt_1",    int'(if_d.frame_cnt), 1);
    step_d(1'b0, "entry+1");
    chk("entry+1.frame_start_lo", int'(if_d.frame_start), 0);
    step_d(1'b0, "entry+2");
    step_d(1'b0, "entry+3");
    step_d(1'b1, "pix1");
    chk("pix1.hcount", int'(if_d.hcount), 1);
    for (int k = 0; k < 3; k++) step_d(1'b0, "pix1");
    $display("default: first frame entered at (0,0), frame_cnt=1");

    // Rest of line 0 at the nominal cadence, through the wrap into line 1.
    for (int i = 0; i < 799; i++) begin
      pixel4_d("line0");
      if (d_h == 639) chk("h639.video_on", int'(if_d.video_on), 1);
      if (d_h == 640) chk("h640.video_on", int'(if_d.video_on), 0);
      if (d_h == 656) chk("h656.hsync",    int'(if_d.hsync), 0);
      if (d_h == 752) chk("h752.hsync",    int'(if_d.hsync), 1);
    end
    chk("wrap.hcount", int'(if_d.hcount), 0);
    chk("wrap.vcount", int'(if_d.vcount), 1);
    $display("default: line 0 swept, wrapped to (0,1)");

    // Back-to-back strobes up to column 300 of line 1.
    for (int i = 0; i < 300; i++) step_d(1'b1, "burst");
    for (int i = 0; i < 50; i++) step_d(1'b0, "stall");
    chk("stall.hcount", int'(if_d.hcount), 300);
    $display("default: 50-clk stall at (300,1)");

    rst_d = 1'b1;
    if_d.pix_en = 1'b1;
    tick();
    rst_d = 1'b0;
    if_d.pix_en = 1'b0;
    d_h = 799; d_v = 524; d_fs = 1'b0; d_fc = 0;
    cmp_d("midrst");
    for (int i = 0; i < 3; i++) step_d(1'b0, "midrst_idle");
    step_d(1'b1, "post_rst");
    chk("post_rst.frame_cnt", int'(if_d.frame_cnt), 1);
    $display("default: mid-frame reset, re-entry at (0,0)");

    // ---------------- 7-pixel lines, full 525-line frames ----------------
    for (int i = 0; i < 3; i++) begin
      if_t.pix_en = ~if_t.pix_en;
      tick();
    end
    t_h = 6; t_v = 524; t_fs = 1'b0; t_fc = 0; t_frames = 0;
    cmp_t("tall_rst");
    rst_t = 1'b0;
    if_t.pix_en = 1'b1;
    for (int i = 0; i < 2 * 7 * 525; i++) begin
      tick();
      adv(7, 525, t_h, t_v, t_fs, t_fc);
      cmp_t("tall");
      if (t_fs) begin
        t_frames++;
        if (t_frames == 2) chk("tall.wrap_frame_cnt", int'(if_t.frame_cnt), 2);
      end
    end
    if_t.pix_en = 1'b0;
    chk("tall.frames_seen", t_frames, 2);
    $display("tall: two full frames swept, vsync/video_on per line checked");

    // ---------------- 7x5 raster, frame_cnt wrap ----------------
    for (int i = 0; i < 3; i++) begin
      if_s.pix_en = ~if_s.pix_en;
      tick();
    end
    s_h = 6; s_v = 4; s_fs = 1'b0; s_fc = 0; s_frames = 0;
    cmp_s("small_rst");
    rst_s = 1'b0;
    if_s.pix_en = 1'b1;
    for (int i = 0; i < 256 * 35; i++) begin
      tick();
      adv(7, 5, s_h, s_v, s_fs, s_fc);
      cmp_s("small");
      if (s_fs) begin
        s_frames++;
        if (s_frames == 256) chk("small.frame_cnt_wrap", int'(if_s.frame_cnt), 0);
      end
    end
    if_s.pix_en = 1'b0;
    chk("small.frames_seen", s_frames, 256);
    $display("small: 256 frames, frame_cnt wrapped to 0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
